eth_unpacker: RTL and testbench
===============================

# eth_unpacker

RMII receive-side frame parser; the inverse of the transmit packer on the same 2-bit PHY link. It hunts for preamble/SFD on `phy_rxd` while `phy_crsdv` is high, strips header and FCS, and streams payload dibits downstream in wire order. A running CRC-32 over header+payload+FCS produces a per-frame good/bad verdict. It sits between the RMII PHY pins and the payload consumer (bit-order reversal / audio sink).

## Interface
- `MIN_PRE_DIBITS`, 15: minimum consecutive `01` dibits required before the SFD `11` dibit.
- `MY_ADDR`, 48'h69695A065491: station address in wire order; dibit k on the wire is `MY_ADDR[47-2k -: 2]`.
- `MAX_DATA_DIBITS`, 6000: payload+FCS dibit limit; exceeding it is an error.

- `clk` in 1: 50 MHz RMII reference clock.
- `rst` in 1: **asynchronous, active-low** reset.
- `phy_crsdv` in 1: carrier sense / data valid.
- `phy_rxd` in 2: receive dibit.
- `axiov` out 1: payload dibit valid.
- `axiod` out 2: payload dibit, same order as received.
- `frame_done` out 1: one-cycle end-of-frame pulse.
- `frame_ok` out 1: CRC good and no error; meaningful only while `frame_done`=1.

## Operation
- States: `WaitQuiet`, `Idle`, `Preamble`, `Header`, `Payload`, `Drop`.
- `WaitQuiet`: entered on reset. Leaves to `Idle` only after `phy_crsdv` is sampled low; the block never locks mid-frame.
- `Idle`: `phy_crsdv`=1 with `phy_rxd`=01 → `Preamble`, pre count=1. Any other dibit with carrier → `Drop`.
- `Preamble`: `01` increments the count (saturate at 63). `11` with count ≥ `MIN_PRE_DIBITS` → `Header`. `11` with a short count, `00`/`10`, or carrier loss → `Drop`, or straight to `Idle` on carrier loss. No `frame_done` is produced from this state.
- `Header`: 56 dibits (24 dest, 24 src, 8 length), counted 0..55, then `Payload`. Length is ignored. Carrier loss → `frame_done`=1, `frame_ok`=0, then `Idle`.
- `Payload`: every dibit enters a 16-dibit (32-bit) delay line. Once the line holds 16 dibits, each new dibit pushes the oldest out on `axiod` with `axiov`=1. On carrier loss the 16 dibits still in the line are the FCS and are never emitted.
- Carrier loss in `Payload` → `frame_done` pulse, then `Idle`.
  - `frame_ok`=1 iff ≥16 payload-state dibits were received, the count ≤ `MAX_DATA_DIBITS`, and CRC residue == 32'h38FB2284.
- Count > `MAX_DATA_DIBITS` → `axiov` held 0, go to `Drop`, flag error. When carrier drops: `frame_done`=1, `frame_ok`=0.
- `Drop`: consume dibits until `phy_crsdv` is low, then go to `Idle`. `frame_done` pulses only if entered from `Header`/`Payload`.
- CRC: a `crc32` instance is fed `phy_rxd` with valid=1 in `Header` and `Payload`. It is reset in `Idle` and by `rst`.
- Payload dibit counter: 13 bits, saturating.

## Timing
- Reset: `axiov`=0, `axiod`=0, `frame_done`=0, `frame_ok`=0, state `WaitQuiet`. Takes effect asynchronously; release is synchronous to `clk`.
- All outputs are registered.
- Payload dibit sampled at edge n appears on `axiod` after edge n+16, i.e. it is emitted with the 16th later dibit, provided carrier stays up.
- `frame_done`/`frame_ok` assert for exactly one cycle after the first edge that samples `phy_crsdv`=0 following `Header`/`Payload`/`Drop`-with-error. `axiov`=0 in that cycle.
- Back-to-back frames: `Idle` accepts a new preamble on the cycle after the `frame_done` cycle. One low carrier cycle is sufficient inter-frame gap.
- No backpressure: the downstream must accept one dibit per cycle while `axiov`=1.

## Configuration
- `ETH_UNPACK_ADDR_FILTER_EN` defined:
  - Dest field is compared dibit-by-dibit against all-ones broadcast and `MY_ADDR`.
  - No match → `Drop` at the end of the dest field; no `axiov`, no `frame_done` for that frame.
- Undefined: no comparison logic; every frame is forwarded regardless of dest.

## Test plan
- 31×`01`, `11`, 24×`11`, 24×`10`, 8 length dibits, 1280 data dibits (pattern k mod 4), correct FCS, carrier drop → exactly 1280 `axiov` cycles matching the pattern in order, then `frame_done`=1 with `frame_ok`=1.
- Same frame with data dibit 500 flipped → 1280 `axiov` cycles (dibit 500 shows the flipped value), `frame_ok`=0.
- Carrier drop after header dibit 10 → zero `axiov`, `frame_done`=1, `frame_ok`=0; next valid frame received with `frame_ok`=1.
- Preamble of 10×`01` then `11` → no `axiov`, no `frame_done`; block returns to `Idle` after carrier drops.
- Filter macro on, dest 24×`00` → no `axiov`, no `frame_done`. Macro off → 1280 dibits forwarded and `frame_ok`=1.
- `rst`=0 mid-payload with carrier high → outputs 0 immediately. After release, frame remainder ignored until carrier low; next frame `frame_ok`=1.

Source files
------------

// File: rtl/eth_unpacker.sv
// RMII receive frame parser: preamble/SFD hunt, header strip, FCS strip, CRC-32 verdict.
// Optional destination filter enabled by defining ETH_UNPACK_ADDR_FILTER_EN.

module crc32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        vld,
  input  logic [1:0]  din,
  output logic [31:0] res
);
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic [31:0] c;

  // MSB-first LFSR; din[0] is the earlier bit on the wire
  function automatic logic [31:0] step(input logic [31:0] s, input logic b);
    return {s[30:0], 1'b0} ^ ((s[31] ^ b) ? POLY : 32'h0);
  endfunction

  always_ff @(posedge clk or negedge rst)
    if (!rst)     c <= '1;
    else if (clr) c <= '1;
    else if (vld) c <= step(step(c, din[0]), din[1]);

  assign res = ~c;
endmodule

module eth_unpacker #(
  parameter int          MIN_PRE_DIBITS  = 15,
  parameter logic [47:0] MY_ADDR         = 48'h69695A065491,
  parameter int          MAX_DATA_DIBITS = 6000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       phy_crsdv,
  input  logic [1:0] phy_rxd,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       frame_done,
  output logic       frame_ok
);
  localparam logic [5:0]  MIN_C = 6'(MIN_PRE_DIBITS);
  localparam logic [12:0] MAX_C = 13'(MAX_DATA_DIBITS);
  localparam logic [31:0] RESIDUE = 32'h38FB2284;

  typedef enum logic [2:0] {WaitQuiet, Idle, Preamble, Header, Payload, Drop} state_t;

  state_t            state, nstate;
  logic [5:0]        pre_cnt, hdr_cnt;
  logic [12:0]       pay_cnt, pay_inc;
  logic              err, ovf, filt_drop;
  logic [15:0][1:0]  dly;
  logic [31:0]       crc_res;
  logic              axiov_d, done_d, ok_d;
  logic [1:0]        axiod_d;

  assign pay_inc = (pay_cnt == 13'h1FFF) ? pay_cnt : pay_cnt + 13'd1;
  assign ovf     = pay_inc > MAX_C;

`ifdef ETH_UNPACK_ADDR_FILTER_EN
  logic        m_bc, m_my, bc_now, my_now;
  logic [47:0] a_sh;
  assign a_sh      = MY_ADDR << {hdr_cnt, 1'b0};
  assign bc_now    = m_bc && (phy_rxd == 2'b11);
  assign my_now    = m_my && (phy_rxd == a_sh[47:46]);
  assign filt_drop = (hdr_cnt == 6'd23) && !(bc_now || my_now);

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      m_bc <= 1'b0;
      m_my <= 1'b0;
    end else if (state == Preamble) begin
      m_bc <= 1'b1;
      m_my <= 1'b1;
    end else if (state == Header && phy_crsdv) begin
      m_bc <= bc_now;
      m_my <= my_now;
    end
`else
  assign filt_drop = 1'b0;
`endif

  crc32 u_crc (
    .clk (clk),
    .rst (rst),
    .clr (state == Idle),
    .vld (phy_crsdv && (state == Header || state == Payload)),
    .din (phy_rxd),
    .res (crc_res)
  );

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= WaitQuiet;
    else      state <= nstate;

  always_comb begin
    nstate = state;
    case (state)
      WaitQuiet: if (!phy_crsdv) nstate = Idle;
      Idle:      if (phy_crsdv) nstate = (phy_rxd == 2'b01) ? Preamble : Drop;
      Preamble:
        if (!phy_crsdv)              nstate = Idle;
        else if (phy_rxd == 2'b11)   nstate = (pre_cnt >= MIN_C) ? Header : Drop;
        else if (phy_rxd != 2'b01)   nstate = Drop;
      Header:
        if (!phy_crsdv)              nstate = Idle;
        else if (filt_drop)          nstate = Drop;
        else if (hdr_cnt == 6'd55)   nstate = Payload;
      Payload:
        if (!phy_crsdv)              nstate = Idle;
        else if (ovf)                nstate = Drop;
      Drop:      if (!phy_crsdv) nstate = Idle;
      default:   nstate = WaitQuiet;
    endcase
  end

  always_comb begin
    axiov_d = (state == Payload) && phy_crsdv && (pay_cnt >= 13'd16) && !ovf;
    axiod_d = axiov_d ? dly[15] : 2'b00;
    done_d  = !phy_crsdv && (state == Header || state == Payload || (state == Drop && err));
    ok_d    = !phy_crsdv && (state == Payload) && (pay_cnt >= 13'd16) &&
              (pay_cnt <= MAX_C) && (crc_res == RESIDUE);
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      axiov      <= 1'b0;
      axiod      <= 2'b00;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
    end else begin
      axiov      <= axiov_d;
      axiod      <= axiod_d;
      frame_done <= done_d;
      frame_ok   <= ok_d;
    end

  // Counters and the 16-dibit FCS-holdback line
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pre_cnt <= '0;
      hdr_cnt <= '0;
      pay_cnt <= '0;
      err     <= 1'b0;
      dly     <= '0;
    end else begin
      case (state)
        Idle: begin
          pre_cnt <= 6'd1;
          err     <= 1'b0;
        end
        Preamble: begin
          if (phy_rxd == 2'b01 && pre_cnt != 6'd63) pre_cnt <= pre_cnt + 6'd1;
          hdr_cnt <= '0;
        end
        Header: begin
          if (phy_crsdv) hdr_cnt <= hdr_cnt + 6'd1;
          pay_cnt <= '0;
        end
        Payload: if (phy_crsdv) begin
          pay_cnt <= pay_inc;
          dly     <= {dly[14:0], phy_rxd};
          if (ovf) err <= 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_eth_unpacker.sv
// Directed bench for eth_unpacker: good/bad CRC, truncation, preamble limits, overflow, reset.
module tb_eth_unpacker;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       phy_crsdv = 1'b0;
  logic [1:0] phy_rxd = 2'b00;
  logic       axiov, frame_done, frame_ok;
  logic [1:0] axiod;

  int total = 0;
  int bad = 0;
  logic [1:0] cap[$];
  int done_cnt = 0;
  int ok_cnt = 0;

  eth_unpacker dut (
    .clk(clk), .rst(rst), .phy_crsdv(phy_crsdv), .phy_rxd(phy_rxd),
    .axiov(axiov), .axiod(axiod), .frame_done(frame_done), .frame_ok(frame_ok)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (axiov) cap.push_back(axiod);
    if (frame_done) done_cnt++;
    if (frame_done && frame_ok) ok_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc2(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] s;
    s = c;
    for (int b = 0; b < 2; b++)
      s = {s[30:0], 1'b0} ^ ((s[31] ^ d[b]) ? 32'h04C11DB7 : 32'h0);
    return s;
  endfunction

  task automatic drive(input logic [1:0] d);
    phy_crsdv = 1'b1;
    phy_rxd   = d;
    @(posedge clk); #1;
  endtask

  task automatic gap();
    phy_crsdv = 1'b0;
    phy_rxd   = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic clr();
    cap.delete();
    done_cnt = 0;
    ok_cnt = 0;
  endtask

  // hlen<56 truncates in the header; flip/rst_at<0 disable those features
  task automatic send_frame(input int npre, input logic [1:0] dest, input int hlen,
                            input int ndata, input int flip, input int nfcs, input int rst_at);
    logic [31:0] c, fcs;
    logic [1:0]  d;
    c = '1;
    for (int i = 0; i < npre; i++) drive(2'b01);
    drive(2'b11);
    for (int i = 0; i < hlen; i++) begin
      d = (i < 24) ? dest : (i < 48) ? 2'b10 : 2'b00;
      c = crc2(c, d);
      drive(d);
    end
    if (hlen == 56) begin
      for (int k = 0; k < ndata; k++) begin
        d = k[1:0];
        c = crc2(c, d);
        if (k == flip) d = d ^ 2'b01;
        if (k == rst_at) begin
          chk("pre_rst_axiov", 32'(axiov), 1);
          rst = 1'b0;
          #1;
          chk("rst_axiov", 32'(axiov), 0);
          chk("rst_axiod", 32'(axiod), 0);
          chk("rst_done", 32'(frame_done), 0);
          chk("rst_ok", 32'(frame_ok), 0);
          clr();
        end
        if (k == rst_at + 2) rst = 1'b1;
        drive(d);
      end
      fcs = ~c;
      for (int j = 0; j < nfcs; j++) drive({fcs[30-2*j], fcs[31-2*j]});
    end
    gap();
  endtask

  task automatic good_frame(input string tag);
    clr();
    send_frame(31, 2'b11, 56, 64, -1, 16, -1);
    gap();
    chk({tag, "_n"}, cap.size(), 64);
    chk({tag, "_ok"}, ok_cnt, 1);
  endtask

  initial begin
    int mism;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_axiov", 32'(axiov), 0);
    chk("reset_axiod", 32'(axiod), 0);
    chk("reset_done", 32'(frame_done), 0);
    chk("reset_ok", 32'(frame_ok), 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Nominal frame: 1280 data dibits in wire order
    clr();
    send_frame(31, 2'b11, 56, 1280, -1, 16, -1);
    gap();
    mism = 0;
    for (int k = 0; k < cap.size(); k++) if (cap[k] !== k[1:0]) mism++;
    chk("good_n", cap.size(), 1280);
    chk("good_pattern", mism, 0);
    chk("good_done", done_cnt, 1);
    chk("good_ok", ok_cnt, 1);

    // Flipped data dibit 500 (500 mod 4 = 0, flipped to 1)
    clr();
    send_frame(31, 2'b11, 56, 1280, 500, 16, -1);
    gap();
    chk("flip_n", cap.size(), 1280);
    chk("flip_d500", (cap.size() > 500) ? 32'(cap[500]) : 32'hFFFF, 1);
    chk("flip_done", done_cnt, 1);
    chk("flip_ok", ok_cnt, 0);

    // Carrier lost after header dibit 10
    clr();
    send_frame(31, 2'b11, 11, 0, -1, 0, -1);
    gap();
    chk("hcut_n", cap.size(), 0);
    chk("hcut_done", done_cnt, 1);
    chk("hcut_ok", ok_cnt, 0);
    good_frame("after_hcut");

    // Short preambles: 10 and 14 dibits rejected, 15 accepted
    clr();
    send_frame(10, 2'b11, 56, 20, -1, 16, -1);
    gap();
    chk("pre10_n", cap.size(), 0);
    chk("pre10_done", done_cnt, 0);
    good_frame("after_pre10");
    clr();
    send_frame(14, 2'b11, 56, 8, -1, 16, -1);
    gap();
    chk("pre14_done", done_cnt, 0);
    clr();
    send_frame(15, 2'b11, 56, 8, -1, 16, -1);
    gap();
    chk("pre15_n", cap.size(), 8);
    chk("pre15_ok", ok_cnt, 1);

    // Unicast dest 24x00
    clr();
    send_frame(31, 2'b00, 56, 1280, -1, 16, -1);
    gap();
`ifdef ETH_UNPACK_ADDR_FILTER_EN
    chk("dest00_n", cap.size(), 0);
    chk("dest00_done", done_cnt, 0);
`else
    chk("dest00_n", cap.size(), 1280);
    chk("dest00_ok", ok_cnt, 1);
`endif

    // Payload length boundaries: 16 (FCS only) good, 15 bad
    clr();
    send_frame(31, 2'b11, 56, 0, -1, 16, -1);
    gap();
    chk("pay16_n", cap.size(), 0);
    chk("pay16_done", done_cnt, 1);
    chk("pay16_ok", ok_cnt, 1);
    clr();
    send_frame(31, 2'b11, 56, 0, -1, 15, -1);
    gap();
    chk("pay15_done", done_cnt, 1);
    chk("pay15_ok", ok_cnt, 0);

    // Max length: 6000 payload dibits accepted, 6001 overflows
    clr();
    send_frame(31, 2'b11, 56, 5984, -1, 16, -1);
    gap();
    chk("max_n", cap.size(), 5984);
    chk("max_ok", ok_cnt, 1);
    clr();
    send_frame(31, 2'b11, 56, 5985, -1, 16, -1);
    gap();
    chk("ovf_n", cap.size(), 5984);
    chk("ovf_done", done_cnt, 1);
    chk("ovf_ok", ok_cnt, 0);

    // Reset mid-payload with carrier up; remainder ignored
    clr();
    send_frame(31, 2'b11, 56, 600, -1, 16, 300);
    gap();
    chk("rstm_n", cap.size(), 0);
    chk("rstm_done", done_cnt, 0);
    good_frame("after_rst");

    // Back-to-back frames separated by a single low cycle
    clr();
    send_frame(31, 2'b11, 56, 100, -1, 16, -1);
    send_frame(31, 2'b11, 56, 100, -1, 16, -1);
    gap();
    chk("b2b_n", cap.size(), 200);
    chk("b2b_done", done_cnt, 2);
    chk("b2b_ok", ok_cnt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
